mem_wb_skid_reg: RTL and testbench
==================================

// Module: mem_wb_skid_reg
// PURPOSE
// - Parametrised MEM->WB pipeline register for the SIMD AES datapath, with a valid/ready handshake on both sides.
// - Replaces the fixed 64-bit, free-running stage register.
// - Adds a 2-entry skid buffer, synchronous flush, per-lane write masks and a stall-cycle counter.
// - Sits between the data-memory stage and register-file writeback; backpressure comes from WB (port contention).
// PARAMETERS
// LANES       4   number of SIMD lanes carried per beat
// LANE_W      64  bits per lane (mem data and ALU result)
// RD_W        5   destination register index width
// CNT_W       16  stall counter width (saturating)
// PORTS
// clk            in   1             rising-edge clock
// rst            in   1             asynchronous, active-high reset
// flush          in   1             synchronous squash of all held and incoming beats
// in_valid       in   1             MEM beat present
// in_ready       out  1             register can accept a beat this cycle
// in_mem_data    in   LANES*LANE_W  load data, lane 0 in LSBs
// in_alu_result  in   LANES*LANE_W  ALU result, lane 0 in LSBs
// in_rd          in   RD_W          destination register
// in_lane_mask   in   LANES         lanes to be written
// in_mem_to_reg  in   1             1 = write mem data, 0 = ALU result
// in_reg_write   in   1             beat writes the register file
// out_valid      out  1             WB beat present
// out_ready      in   1             WB consumes beat this cycle
// out_mem_data / out_alu_result / out_rd / out_lane_mask / out_mem_to_reg  out  as inputs  held beat fields
// out_reg_write  out  1             stored reg_write AND out_valid
// out_lane_we    out  LANES         out_lane_mask & {LANES{out_reg_write}}
// stall_cycles   out  CNT_W         cycles with out_valid & !out_ready
// BEHAVIOUR
// - Reset (async, immediate): out_valid=0, skid empty, all out_* data/ctrl=0, stall_cycles=0, in_ready=1.
// - Transfers:
//   - accept = in_valid & in_ready; issue = out_valid & out_ready.
//   - in_ready = !skid_valid, taken straight from a flop (no combinational path from out_ready).
// - Latency: 1 cycle from accept to out_valid when the skid is empty. Throughput: 1 beat/cycle.
// - Main-register update per edge (flush=0):
//   - main empty or issue, skid_valid: main<=skid, skid empties; an accept in the same cycle loads skid.
//   - main empty or issue, skid empty: main<=input if accept, else out_valid<=0.
//   - main held (no issue), accept: input -> skid, skid_valid<=1, in_ready drops next cycle.
// - Ordering: beats leave in acceptance order; no beat is lost or duplicated.
// - Flush:
//   - out_valid<=0 and skid_valid<=0 on the next edge.
//   - A beat accepted in the flush cycle is dropped; an issue in the flush cycle still completes.
//   - Flush has priority over every other update. Data fields may hold stale values; out_reg_write and out_lane_we are 0.
// - Invalid beats never write: out_reg_write and out_lane_we are forced 0 whenever out_valid=0.
// - stall_cycles: +1 on each edge with out_valid & !out_ready; saturates at 2^CNT_W-1; cleared only by rst; flush does not clear it.
// - Reset mid-transfer: both entries are discarded instantly; in_ready returns to 1 while rst is high.
// STRUCTURE
// - pipe_pkg:
//   - typedef struct packed wb_beat_t {mem_data, alu_result, rd, lane_mask, mem_to_reg, reg_write}, sized from the package constants.
//   - localparam WB_BEAT_RESET = '0.
// - Sub-module pipe_skid_buf #(type T): generic 2-entry valid/ready skid with flush.
// - mem_wb_skid_reg instantiates pipe_skid_buf, adds write-enable gating and the stall counter.
// TESTING
// 1. Reset: assert rst mid-stream with 2 beats held -> out_valid=0, in_ready=1, stall_cycles=0, all outs 0 immediately.
// 2. Streaming: out_ready=1, 8 back-to-back beats rd=1..8 -> out rd=1..8 on consecutive cycles, each 1 cycle after accept, in_ready stays 1.
// 3. Backpressure: out_ready=0 for 3 cycles while beats rd=3,4 arrive -> in_ready=0 after the 2nd accept, stall_cycles=3, then rd=3,4 issue in order.
// 4. Flush: skid and main full (rd=5,6), flush=1 with in_valid rd=7 -> next cycle out_valid=0, in_ready=1, rd=5,6,7 never issued.
// 5. Write gating: reg_write=1, lane_mask=4'b1010 -> out_lane_we=4'b1010 while valid; reg_write=0 -> out_lane_we=0.
// 6. Saturation: CNT_W=4, out_ready=0 for 20 cycles with a valid beat -> stall_cycles holds at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared beat definition for the MEM->WB pipeline register.
package pipe_pkg;

  localparam int BEAT_LANES  = 4;
  localparam int BEAT_LANE_W = 64;
  localparam int BEAT_RD_W   = 5;
  localparam int DEF_CNT_W   = 16;

  typedef struct packed {
    logic [BEAT_LANES*BEAT_LANE_W-1:0] mem_data;
    logic [BEAT_LANES*BEAT_LANE_W-1:0] alu_result;
    logic [BEAT_RD_W-1:0]              rd;
    logic [BEAT_LANES-1:0]             lane_mask;
    logic                              mem_to_reg;
    logic                              reg_write;
  } wb_beat_t;

  localparam wb_beat_t WB_BEAT_RESET = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid register with synchronous flush.
// in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
module pipe_skid_buf #(
  parameter type T         = logic [7:0],
  parameter T    RESET_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic skid_valid;
  T     skid_data;
  logic accept;
  logic load_main;

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign load_main = ~out_valid | out_ready;

  // main stage refills from skid first to keep acceptance order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= RESET_VAL;
      skid_data  <= RESET_VAL;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_main) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= accept;
        if (accept) skid_data <= in_data;
      end else begin
        out_valid <= accept;
        if (accept) out_data <= in_data;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register: skid-buffered beat, write-enable gating
// and a saturating count of backpressured cycles.
module mem_wb_skid_reg
  import pipe_pkg::*;
#(
  parameter int LANES  = BEAT_LANES,
  parameter int LANE_W = BEAT_LANE_W,
  parameter int RD_W   = BEAT_RD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_mem_data,
  input  logic [LANES*LANE_W-1:0] in_alu_result,
  input  logic [RD_W-1:0]         in_rd,
  input  logic [LANES-1:0]        in_lane_mask,
  input  logic                    in_mem_to_reg,
  input  logic                    in_reg_write,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_mem_data,
  output logic [LANES*LANE_W-1:0] out_alu_result,
  output logic [RD_W-1:0]         out_rd,
  output logic [LANES-1:0]        out_lane_mask,
  output logic                    out_mem_to_reg,
  output logic                    out_reg_write,
  output logic [LANES-1:0]        out_lane_we,
  output logic [CNT_W-1:0]        stall_cycles
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  wb_beat_t in_beat;
  wb_beat_t out_beat;

  assign in_beat.mem_data   = in_mem_data;
  assign in_beat.alu_result = in_alu_result;
  assign in_beat.rd         = in_rd;
  assign in_beat.lane_mask  = in_lane_mask;
  assign in_beat.mem_to_reg = in_mem_to_reg;
  assign in_beat.reg_write  = in_reg_write;

  pipe_skid_buf #(
    .T         (wb_beat_t),
    .RESET_VAL (WB_BEAT_RESET)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_beat)
  );

  assign out_mem_data   = out_beat.mem_data;
  assign out_alu_result = out_beat.alu_result;
  assign out_rd         = out_beat.rd;
  assign out_lane_mask  = out_beat.lane_mask;
  assign out_mem_to_reg = out_beat.mem_to_reg;

  // stale data after a flush must never reach the register file
  assign out_reg_write  = out_beat.reg_write & out_valid;
  assign out_lane_we    = out_beat.lane_mask & {LANES{out_reg_write}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: directed vector table, hand sequences for
// saturation and async reset, then random traffic against a queue model.
module tb_mem_wb_skid_reg;
  import pipe_pkg::*;

  localparam int L  = BEAT_LANES;
  localparam int W  = BEAT_LANE_W;
  localparam int DW = L * W;
  localparam int RW = BEAT_RD_W;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_mem_data;
  logic [DW-1:0] in_alu_result;
  logic [RW-1:0] in_rd;
  logic [L-1:0]  in_lane_mask;
  logic          in_mem_to_reg;
  logic          in_reg_write;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_mem_data;
  logic [DW-1:0] out_alu_result;
  logic [RW-1:0] out_rd;
  logic [L-1:0]  out_lane_mask;
  logic          out_mem_to_reg;
  logic          out_reg_write;
  logic [L-1:0]  out_lane_we;
  logic [CW-1:0] stall_cycles;

  mem_wb_skid_reg #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mem_data    (in_mem_data),
    .in_alu_result  (in_alu_result),
    .in_rd          (in_rd),
    .in_lane_mask   (in_lane_mask),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_reg_write   (in_reg_write),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_mem_data   (out_mem_data),
    .out_alu_result (out_alu_result),
    .out_rd         (out_rd),
    .out_lane_mask  (out_lane_mask),
    .out_mem_to_reg (out_mem_to_reg),
    .out_reg_write  (out_reg_write),
    .out_lane_we    (out_lane_we),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [RW-1:0] r);
    return {8{27'd0, r}};
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [RW-1:0] r, input logic [L-1:0] m, input logic rw);
    in_valid      = iv;
    out_ready     = ordy;
    flush         = fl;
    in_rd         = r;
    in_lane_mask  = m;
    in_reg_write  = rw;
    in_mem_to_reg = r[0];
    in_mem_data   = pat(r);
    in_alu_result = ~pat(r);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, DW'(out_valid), DW'(0));
    chk({tag, "_in_ready"}, DW'(in_ready), DW'(1));
    chk({tag, "_stall"}, DW'(stall_cycles), DW'(0));
    chk({tag, "_mem_data"}, out_mem_data, '0);
    chk({tag, "_alu_result"}, out_alu_result, '0);
    chk({tag, "_ctrl"}, DW'({out_rd, out_lane_mask, out_mem_to_reg, out_reg_write, out_lane_we}), DW'(0));
  endtask

  typedef struct {
    logic          iv, ordy, fl;
    logic [RW-1:0] rd;
    logic [L-1:0]  mask;
    logic          rw;
    logic          ev, erdy;
    logic [RW-1:0] erd;
    logic [L-1:0]  ewe;
    logic [CW-1:0] est;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(logic iv, logic ordy, logic fl, logic [RW-1:0] rd, logic [L-1:0] mask,
                               logic rw, logic ev, logic erdy, logic [RW-1:0] erd, logic [L-1:0] ewe,
                               logic [CW-1:0] est);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.rd = rd; v.mask = mask; v.rw = rw;
    v.ev = ev; v.erdy = erdy; v.erd = erd; v.ewe = ewe; v.est = est;
    vecs.push_back(v);
  endfunction

  wb_beat_t q[$];
  int       mst;

  initial begin
    // streaming: rd 1..8 back to back
    for (int k = 1; k <= 8; k++) addv(1, 1, 0, RW'(k), 4'hF, 1, 1, 1, RW'(k), 4'hF, 0);
    addv(0, 1, 0, 0,  4'hF, 1, 0, 1, 0,  4'h0, 0);
    // backpressure
    addv(1, 0, 0, 3,  4'hF, 1, 1, 1, 3,  4'hF, 0);
    addv(1, 0, 0, 4,  4'hF, 1, 1, 0, 3,  4'hF, 1);
    addv(0, 0, 0, 0,  4'hF, 1, 1, 0, 3,  4'hF, 2);
    addv(0, 0, 0, 0,  4'hF, 1, 1, 0, 3,  4'hF, 3);
    addv(0, 1, 0, 0,  4'hF, 1, 1, 1, 4,  4'hF, 3);
    addv(0, 1, 0, 0,  4'hF, 1, 0, 1, 0,  4'h0, 3);
    // flush with both entries full
    addv(1, 0, 0, 5,  4'hF, 1, 1, 1, 5,  4'hF, 3);
    addv(1, 0, 0, 6,  4'hF, 1, 1, 0, 5,  4'hF, 4);
    addv(1, 0, 1, 7,  4'hF, 1, 0, 1, 0,  4'h0, 5);
    addv(0, 1, 0, 0,  4'hF, 1, 0, 1, 0,  4'h0, 5);
    // flush drops an accepted beat while an issue completes
    addv(1, 1, 0, 9,  4'hF, 1, 1, 1, 9,  4'hF, 5);
    addv(1, 1, 1, 10, 4'hF, 1, 0, 1, 0,  4'h0, 5);
    addv(0, 1, 0, 0,  4'hF, 1, 0, 1, 0,  4'h0, 5);
    // write gating
    addv(1, 0, 0, 11, 4'hA, 1, 1, 1, 11, 4'hA, 5);
    addv(0, 1, 0, 0,  4'hA, 1, 0, 1, 0,  4'h0, 5);
    addv(1, 1, 0, 12, 4'hA, 0, 1, 1, 12, 4'h0, 5);
    addv(0, 1, 0, 0,  4'hA, 0, 0, 1, 0,  4'h0, 5);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk_zero_outputs("reset_initial");
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].rd, vecs[i].mask, vecs[i].rw);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].ev));
      chk($sformatf("v%0d_in_ready", i), DW'(in_ready), DW'(vecs[i].erdy));
      chk($sformatf("v%0d_lane_we", i), DW'(out_lane_we), DW'(vecs[i].ewe));
      chk($sformatf("v%0d_stall", i), DW'(stall_cycles), DW'(vecs[i].est));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_rd", i), DW'(out_rd), DW'(vecs[i].erd));
        chk($sformatf("v%0d_mem_data", i), out_mem_data, pat(vecs[i].erd));
        chk($sformatf("v%0d_alu_result", i), out_alu_result, ~pat(vecs[i].erd));
      end
    end

    // saturation: one beat held for 20 cycles
    drive(1, 0, 0, 13, 4'h3, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 4'h0, 0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("sat_stall", DW'(stall_cycles), DW'(SAT));
    chk("sat_held_rd", DW'({out_valid, out_rd, out_lane_we}), DW'({1'b1, 5'd13, 4'h3}));

    // async reset with main and skid both occupied
    drive(1, 0, 0, 14, 4'hF, 1);
    @(posedge clk); #1;
    chk("pre_reset_in_ready", DW'(in_ready), DW'(0));
    drive(0, 0, 0, 0, 4'h0, 0);
    #2 rst = 1'b1;
    #1;
    chk_zero_outputs("reset_async");
    @(posedge clk); #1;
    chk("reset_hold_in_ready", DW'({in_ready, out_valid}), DW'(2'b10));
    rst = 1'b0;

    // random traffic against a 2-deep in-order queue model
    mst = 0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      wb_beat_t b;
      logic iv, ordy, fl, acc, iss, stl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < DW / 32; k++) begin
        b.mem_data[k*32 +: 32]   = $urandom();
        b.alu_result[k*32 +: 32] = $urandom();
      end
      b.rd         = RW'($urandom());
      b.lane_mask  = L'($urandom());
      b.mem_to_reg = 1'($urandom());
      b.reg_write  = 1'($urandom());
      in_valid = iv; out_ready = ordy; flush = fl;
      in_mem_data = b.mem_data; in_alu_result = b.alu_result; in_rd = b.rd;
      in_lane_mask = b.lane_mask; in_mem_to_reg = b.mem_to_reg; in_reg_write = b.reg_write;
      acc = iv && (q.size() < 2);
      iss = (q.size() > 0) && ordy;
      stl = (q.size() > 0) && !ordy;
      @(posedge clk); #1;
      if (stl && mst < SAT) mst++;
      if (fl) q.delete();
      else begin
        if (iss) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
      chk($sformatf("r%0d_out_valid", c), DW'(out_valid), DW'(q.size() > 0));
      chk($sformatf("r%0d_in_ready", c), DW'(in_ready), DW'(q.size() < 2));
      chk($sformatf("r%0d_stall", c), DW'(stall_cycles), DW'(mst));
      if (q.size() > 0) begin
        chk($sformatf("r%0d_mem_data", c), out_mem_data, q[0].mem_data);
        chk($sformatf("r%0d_alu_result", c), out_alu_result, q[0].alu_result);
        chk($sformatf("r%0d_ctrl", c), DW'({out_rd, out_lane_mask, out_mem_to_reg, out_reg_write, out_lane_we}),
            DW'({q[0].rd, q[0].lane_mask, q[0].mem_to_reg, q[0].reg_write,
                 q[0].lane_mask & {L{q[0].reg_write}}}));
      end else begin
        chk($sformatf("r%0d_idle_we", c), DW'({out_reg_write, out_lane_we}), DW'(0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
